// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : MIPS ID stage - register file with WB write/bypass, opcode
//               control decode, immediate sign-extension and ID/EX latch.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter logic [5:0] NOP_OPCODE = 6'b100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] if_id_npc,
    input  logic        flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic [1:0]  id_ex_wb,
    output logic [2:0]  id_ex_m,
    output logic [3:0]  id_ex_ex,
    output logic [31:0] id_ex_npc,
    output logic [31:0] id_ex_rd1,
    output logic [31:0] id_ex_rd2,
    output logic [31:0] id_ex_sign_ext,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_rd
);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_sign_ext;
    logic        w_wb_write_valid;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [1:0]  w_wb;
    logic [2:0]  w_m;
    logic [3:0]  w_ex;

    logic [31:0] r_regs [32];

    logic [1:0]  r_wb;
    logic [2:0]  r_m;
    logic [3:0]  r_ex;
    logic [31:0] r_npc;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_sign_ext;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;

    assign w_opcode   = if_id_instr[31:26];
    assign w_rs       = if_id_instr[25:21];
    assign w_rt       = if_id_instr[20:16];
    assign w_rd       = if_id_instr[15:11];
    assign w_sign_ext = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

    // r0 is hard-wired to zero, so writes targeting it are discarded outright
    assign w_wb_write_valid = wb_reg_write && (wb_write_reg != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write_valid) begin
            r_regs[wb_write_reg] <= wb_write_data;
        end
    end

    // Write-before-read: a WB write this cycle is visible to the decode reads
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_rs != 5'd0) begin
            w_rd1 = (w_wb_write_valid && (wb_write_reg == w_rs)) ? wb_write_data : r_regs[w_rs];
        end
        if (w_rt != 5'd0) begin
            w_rd2 = (w_wb_write_valid && (wb_write_reg == w_rt)) ? wb_write_data : r_regs[w_rt];
        end
    end

    always_comb begin
        w_wb = 2'b00;
        w_m  = 3'b000;
        w_ex = 4'b0000;
        if (w_opcode != NOP_OPCODE) begin
            case (w_opcode)
                c_op_rtype: begin
                    w_wb = 2'b10;
                    w_m  = 3'b000;
                    w_ex = 4'b1100;
                end
                c_op_lw: begin
                    w_wb = 2'b11;
                    w_m  = 3'b010;
                    w_ex = 4'b0001;
                end
                c_op_sw: begin
                    w_wb = 2'b00;
                    w_m  = 3'b001;
                    w_ex = 4'b0001;
                end
                c_op_beq: begin
                    w_wb = 2'b00;
                    w_m  = 3'b100;
                    w_ex = 4'b0010;
                end
                default: begin
                    w_wb = 2'b00;
                    w_m  = 3'b000;
                    w_ex = 4'b0000;
                end
            endcase
        end
    end

    // A flush only turns the control into a bubble; data fields still advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb       <= '0;
            r_m        <= '0;
            r_ex       <= '0;
            r_npc      <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_sign_ext <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
        end else begin
            r_wb       <= flush ? 2'b00   : w_wb;
            r_m        <= flush ? 3'b000  : w_m;
            r_ex       <= flush ? 4'b0000 : w_ex;
            r_npc      <= if_id_npc;
            r_rd1      <= w_rd1;
            r_rd2      <= w_rd2;
            r_sign_ext <= w_sign_ext;
            r_rt       <= w_rt;
            r_rd       <= w_rd;
        end
    end

    assign id_ex_wb       = r_wb;
    assign id_ex_m        = r_m;
    assign id_ex_ex       = r_ex;
    assign id_ex_npc      = r_npc;
    assign id_ex_rd1      = r_rd1;
    assign id_ex_rd2      = r_rd2;
    assign id_ex_sign_ext = r_sign_ext;
    assign id_ex_rt       = r_rt;
    assign id_ex_rd       = r_rd;

endmodule
`default_nettype wire
